// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer: holds the PLL in reset, qualifies LOCK, then releases sys_rst_n.
// Optional PLL_SEQ_BYPASS_FALLBACK_EN: FAULT runs the system from the reference clock via PLL bypass.
module pll_lock_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int unsigned MaxTiming =
        (HOLD_CYCLES > LOCK_TIMEOUT)
            ? ((HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES)
            : ((LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES);
    localparam int unsigned CntW = $clog2(MaxTiming) + 1;

    localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [3:0]      RetryMax    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StHold,
        StWaitLock,
        StSettle,
        StRun,
        StFault
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic            lock_meta_q, lock_s_q;
    logic            pll_resetb_q, pll_resetb_d;
    logic            sys_rst_n_q, sys_rst_n_d;
    logic            locked_q, locked_d;
    logic            fault_q, fault_d;

    logic hold_done;
    logic timeout_done;
    logic settle_done;

    assign hold_done    = (cnt_q == HoldLast);
    assign timeout_done = (cnt_q == TimeoutLast);
    assign settle_done  = (cnt_q == SettleLast);

    // pll_lock is asynchronous to clk; nothing downstream sees it before lock_s_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;

        if (relock_req) begin
            state_d = StHold;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                StHold: begin
                    if (hold_done) begin
                        state_d = StWaitLock;
                    end
                end
                StWaitLock: begin
                    // A lock arriving on the timeout cycle still counts as a lock.
                    if (lock_s_q) begin
                        state_d = StSettle;
                    end else if (timeout_done) begin
                        if (retry_q < RetryMax) begin
                            retry_d = retry_q + 4'd1;
                            state_d = StHold;
                        end else begin
                            state_d = StFault;
                        end
                    end
                end
                StSettle: begin
                    if (!lock_s_q) begin
                        state_d = StWaitLock;
                    end else if (settle_done) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!lock_s_q) begin
                        state_d = StHold;
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
                default: begin
                    state_d = StHold;
                end
            endcase
        end

        if (state_d == StRun) begin
            retry_d = 4'd0;
        end
    end

    // Counter runs only in the timed states and restarts on every transition or relock.
    always_comb begin
        cnt_d = cnt_q;
        if (relock_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == StHold) || (state_q == StWaitLock) || (state_q == StSettle)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_comb begin
        pll_resetb_d = (state_d != StHold) && (state_d != StFault);
        locked_d     = (state_d == StRun);
        fault_d      = (state_d == StFault);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
        sys_rst_n_d  = (state_d == StRun) || (state_d == StFault);
`else
        sys_rst_n_d  = (state_d == StRun);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            pll_resetb_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_resetb_q <= pll_resetb_d;
            sys_rst_n_q  <= sys_rst_n_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
        end
    end

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    logic pll_bypass_q, pll_bypass_d;

    assign pll_bypass_d = (state_d == StFault);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pll_bypass_q <= 1'b0;
        end else begin
            pll_bypass_q <= pll_bypass_d;
        end
    end

    assign pll_bypass = pll_bypass_q;
`else
    assign pll_bypass = 1'b0;
`endif

    assign pll_resetb  = pll_resetb_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer with HOLD=4, TIMEOUT=20, SETTLE=8, RETRIES=2.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [3:0] retry_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_v;
    logic [8:0] outs;

    assign outs = {pll_resetb, pll_bypass, sys_rst_n, locked, fault, retry_count};

    pll_lock_sequencer #(
        .HOLD_CYCLES  (4),
        .LOCK_TIMEOUT (20),
        .SETTLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_resetb (pll_resetb),
        .pll_bypass (pll_bypass),
        .sys_rst_n  (sys_rst_n),
        .locked     (locked),
        .fault      (fault),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    // Packs {pll_resetb, pll_bypass, sys_rst_n, locked, fault, retry_count}.
    function automatic logic [8:0] ex(input logic rb, input logic bp, input logic sr,
                                      input logic lk, input logic ft, input logic [3:0] rc);
        return {rb, bp, sr, lk, ft, rc};
    endfunction

    function automatic logic [8:0] ex_fault();
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
        return ex(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
`else
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; the next edge becomes edge 1 of the new sequence.
    task automatic restart(input logic lock_val);
        resetn   = 1'b0;
        pll_lock = lock_val;
        #2;
        resetn   = 1'b1;
    endtask

    task automatic test_reset();
        tick(2);
        exp_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL reset_values: got %b want %b", outs, exp_v); end
        #2;
        resetn = 1'b1;
        tick(3);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL hold_edge3: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL resetb_edge4: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_clean_lock();
        tick(5);
        pll_lock = 1'b1;
        tick(10);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL clean_pre_release: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL clean_release: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_lost_lock();
        pll_lock = 1'b0;
        tick(2);
        exp_v = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lost_k1: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lost_k2: got %b want %b", outs, exp_v); end
        tick(3);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lost_hold_end: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lost_wait: got %b want %b", outs, exp_v); end
        pll_lock = 1'b1;
        tick(10);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lost_pre_release: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL lost_release: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_relock_run();
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        exp_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL relock_run_hold: got %b want %b", outs, exp_v); end
        tick(3);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL relock_run_hold3: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL relock_run_wait: got %b want %b", outs, exp_v); end
        tick(8);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL relock_run_settle: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL relock_run_release: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_settle_glitch();
        pll_lock   = 1'b0;
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        tick(4);
        pll_lock = 1'b1;   // first sampled at edge k
        tick(7);           // edge k+6
        pll_lock = 1'b0;
        tick(1);           // edge k+7 samples the drop
        pll_lock = 1'b1;
        tick(3);           // edge k+10: undisturbed release edge
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL glitch_no_release: got %b want %b", outs, exp_v); end
        tick(7);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL glitch_pre_release: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL glitch_release: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_lock_at_timeout();
        restart(1'b0);
        tick(21);
        pll_lock = 1'b1;   // lock_s first seen by the FSM on edge 24, the timeout edge
        tick(3);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_lock_wins: got %b want %b", outs, exp_v); end
        tick(7);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_lock_pre: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_lock_release: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_timeouts();
        restart(1'b0);
        tick(23);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_edge23: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_edge24: got %b want %b", outs, exp_v); end
        tick(4);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_edge28: got %b want %b", outs, exp_v); end
        tick(20);
        exp_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_edge48: got %b want %b", outs, exp_v); end
        tick(23);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_edge71: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex_fault();
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL tmo_fault72: got %b want %b", outs, exp_v); end
        tick(30);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL fault_sticky: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_relock_fault();
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        exp_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL relock_fault_hold: got %b want %b", outs, exp_v); end
        tick(4);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL relock_fault_wait: got %b want %b", outs, exp_v); end
    endtask

    task automatic test_reset_mid_settle();
        pll_lock = 1'b1;
        tick(4);           // SETTLE entered two edges after the first lock sample
        resetn = 1'b0;
        #1;
        exp_v = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL async_reset: got %b want %b", outs, exp_v); end
        #1;
        resetn = 1'b1;
        tick(3);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL restart_hold3: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL restart_wait: got %b want %b", outs, exp_v); end
        tick(8);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL restart_pre: got %b want %b", outs, exp_v); end
        tick(1);
        exp_v = ex(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        n_tests++;
        if (outs !== exp_v) begin n_fail++; $display("FAIL restart_release: got %b want %b", outs, exp_v); end
    endtask

    initial begin
        resetn     = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_clean_lock();
        test_lost_lock();
        test_relock_run();
        test_settle_glitch();
        test_lock_at_timeout();
        test_timeouts();
        test_relock_fault();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Power-up and recovery sequencer for the iCE40 PLL primitive; it runs on the 12 MHz board oscillator (the PLL reference) and owns the PLL's RESETB and BYPASS pins. It holds the PLL in reset, waits for a qualified LOCK, then releases a downstream system reset. It retries on lock timeout and restarts on loss of lock. It sits between the top-level oscillator pin and every block clocked from PLLOUTCORE.

## Interface
Parameters:
- HOLD_CYCLES, 16: cycles pll_resetb is held low per attempt (≥1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before an attempt fails (≥2).
- SETTLE_CYCLES, 256: consecutive synchronized-lock cycles required before release (≥1).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (0..15).

Ports:
- clk  in  1  reference clock (oscillator); all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK output; asynchronous to clk.
- relock_req  in  1  single-cycle pulse; forces a fresh sequence.
- pll_resetb  out  1  to PLL RESETB; 0 = PLL in reset.
- pll_bypass  out  1  to PLL BYPASS.
- sys_rst_n  out  1  downstream reset; 1 only while PLL output is usable.
- locked  out  1  high in RUN.
- fault  out  1  high in FAULT.
- retry_count  out  4  failed attempts since last RUN or relock_req.

## Operation
- pll_lock passes through a 2-flop synchronizer (lock_s) before any use.
- One cycle counter (width clog2 of largest timing parameter, +1), cleared on every state change.
- States:
  - HOLD: pll_resetb=0. When the counter reaches HOLD_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_resetb=1. If lock_s=1, go to SETTLE. If the counter reaches LOCK_TIMEOUT-1 first:
    - if retry_count<MAX_RETRIES: increment retry_count, go to HOLD;
    - otherwise go to FAULT.
  - SETTLE: if lock_s=0, return to WAIT_LOCK with no retry increment. If the counter reaches SETTLE_CYCLES-1 with lock_s high throughout, go to RUN.
  - RUN: sys_rst_n=1, locked=1, retry_count cleared on entry. If lock_s=0, go to HOLD; sys_rst_n drops on that same edge.
  - FAULT: pll_resetb=0, sys_rst_n=0, fault=1. Exit only via relock_req or resetn.
- relock_req in any state: go to HOLD and clear retry_count. It takes priority over every other transition in that cycle.
- Simultaneous events:
  - lock_s rising on the WAIT_LOCK timeout cycle: lock wins, go to SETTLE.
  - lock_s falling on the final SETTLE cycle: go to WAIT_LOCK.
- All outputs are registered, decoded from the next state.

## Timing
- Reset values: state=HOLD, pll_resetb=0, pll_bypass=0, sys_rst_n=0, locked=0, fault=0, retry_count=0, synchronizer flops=0.
- resetn assertion clears everything immediately, mid-sequence included. The first rising edge after deassertion is counted as HOLD cycle 0.
- pll_resetb rises on edge HOLD_CYCLES after reset release.
- pll_lock sampled high first at edge k:
  - lock_s is high after edge k+1;
  - SETTLE is entered at edge k+2;
  - sys_rst_n and locked rise at edge k+2+SETTLE_CYCLES.
- pll_lock falling, sampled at edge k during RUN: sys_rst_n falls at edge k+2.
- A timeout attempt spans HOLD_CYCLES+LOCK_TIMEOUT cycles.
- sys_rst_n never glitches; it is a single flop output.

## Configuration
- PLL_SEQ_BYPASS_FALLBACK_EN defined: FAULT instead drives pll_bypass=1, pll_resetb=0, sys_rst_n=1, locked=0, fault=1. The system therefore runs from the reference clock routed through the PLL bypass. relock_req clears pll_bypass on its HOLD entry edge.
- Macro undefined: pll_bypass is tied 0 and FAULT holds sys_rst_n=0.

## Test plan
Test parameters: HOLD_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: pll_lock rises 5 cycles after pll_resetb rises -> sys_rst_n rises exactly 10 edges after lock is first sampled; retry_count=0.
- Settle glitch: lock drops for 1 cycle at SETTLE cycle 5 -> returns to WAIT_LOCK; sys_rst_n stays 0; release happens 10 edges after lock re-rises; retry_count=0.
- Timeouts: pll_lock held 0 -> pll_resetb low pulses at 24-cycle spacing, retry_count 1 then 2, then FAULT at cycle 72 with fault=1 and sys_rst_n=0. With PLL_SEQ_BYPASS_FALLBACK_EN: pll_bypass=1 and sys_rst_n=1.
- Lost lock in RUN: lock falls -> sys_rst_n=0 two edges later; pll_resetb low for 4 cycles; the sequence resumes.
- relock_req in FAULT and in RUN -> HOLD next edge, retry_count=0, pll_bypass=0.
- resetn asserted mid-SETTLE -> all outputs at reset values with no clock edge; the sequence restarts cleanly.
